// File: rtl/data_mem_responder_pkg.sv
// Shared constants for the data memory responder: FSM encoding, window geometry,
// default depth and a helper for the array index width.
package data_mem_responder_pkg;

  localparam logic [31:0] WIN_BASE = 32'h0000_192E;
  localparam logic [31:0] WIN_LAST = 32'h0000_1D2D;

  // Window span in words; the default array depth covers the whole window.
  localparam int unsigned DEPTH_DEFAULT = 32'(WIN_LAST - WIN_BASE) + 32'd1;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  function automatic int unsigned idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// DEPTH x 32 storage: synchronous write, combinational read, no reset.
module data_mem_array
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = idx_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_c_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_c_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding memory responder: latches one request, waits WAIT_STATES
// cycles, then returns a one-cycle ACK with read data or an out-of-range ERR.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH       = DEPTH_DEFAULT,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              CS,
  input  logic              iWE,
  input  logic [31:0]       iAddress,
  input  logic              REQ,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              ACK,
  output logic              ERR,
  output logic              BUSY
);

  localparam int unsigned       AW       = idx_width(DEPTH);
  localparam logic [CNT_W-1:0]  CNT_INIT = (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam logic [31:0]       DEPTH_W  = 32'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              accept;
  logic [31:0]       sel_addr;
  logic              sel_we;
  logic              sel_in_range;
  logic [AW-1:0]     mem_idx;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  // In IDLE the live request is looked at so a zero-wait access can answer next cycle.
  assign accept       = (state_q == ST_IDLE) && REQ && CS;
  assign sel_addr     = (state_q == ST_IDLE) ? iAddress : addr_q;
  assign sel_we       = (state_q == ST_IDLE) ? iWE : we_q;
  assign sel_in_range = (sel_addr < DEPTH_W);
  assign mem_idx      = sel_addr[AW-1:0];
  assign mem_we       = (state_q == ST_RESP) && sel_we && sel_in_range;

  data_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i     (CLK),
    .we_i      (mem_we),
    .addr_i    (mem_idx),
    .wdata_i   (wdata_q),
    .rdata_c_o (mem_rdata)
  );

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = iAddress;
          we_d    = iWE;
          wdata_d = WriteData;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Response outputs are registered on the edge that enters RESP.
    ack_d   = (state_d == ST_RESP);
    busy_d  = (state_d != ST_IDLE);
    err_d   = ack_d && !sel_in_range;
    rdata_d = (ack_d && !sel_we && sel_in_range) ? mem_rdata : '0;
  end

  assign ReadData = rdata_q;
  assign ACK      = ack_q;
  assign ERR      = err_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: WAIT_STATES=2 and WAIT_STATES=0 instances,
// directed and random transfers checked against a word-level memory model.
module tb_data_mem_responder;

  logic        CLK = 1'b0;
  logic        RST_n, REQ, CS, iWE;
  logic [31:0] iAddress, WriteData;
  logic        sel;

  logic [31:0] rd_a, rd_b, rdata;
  logic        ack_a, ack_b, err_a, err_b, busy_a, busy_b;
  logic        ack, err, busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] mem_a [int unsigned];
  logic [31:0] mem_b [int unsigned];
  int unsigned addr_set [$];

  always #5 CLK = ~CLK;

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(2)) dut_a (
    .CLK(CLK), .RST_n(RST_n), .CS(CS & ~sel), .iWE(iWE), .iAddress(iAddress),
    .REQ(REQ), .WriteData(WriteData), .ReadData(rd_a), .ACK(ack_a),
    .ERR(err_a), .BUSY(busy_a)
  );

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) dut_b (
    .CLK(CLK), .RST_n(RST_n), .CS(CS & sel), .iWE(iWE), .iAddress(iAddress),
    .REQ(REQ), .WriteData(WriteData), .ReadData(rd_b), .ACK(ack_b),
    .ERR(err_b), .BUSY(busy_b)
  );

  assign rdata = sel ? rd_b   : rd_a;
  assign ack   = sel ? ack_b  : ack_a;
  assign err   = sel ? err_b  : err_a;
  assign busy  = sel ? busy_b : busy_a;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word-level reference: out-of-range never touches memory, writes return zero data.
  function automatic logic [31:0] model_xfer(input logic we, input logic [31:0] addr,
                                             input logic [31:0] wd, output logic exp_err);
    exp_err = (addr >= 32'd1024);
    if (exp_err) return 32'd0;
    if (we) begin
      if (sel) mem_b[addr] = wd;
      else     mem_a[addr] = wd;
      return 32'd0;
    end
    return sel ? mem_b[addr] : mem_a[addr];
  endfunction

  // Called just after a negedge; leaves the bench at the negedge where the DUT is idle again.
  task automatic xfer(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input bit glitch);
    int          w;
    logic [31:0] exp_rd;
    logic        exp_err;
    w      = sel ? 0 : 2;
    exp_rd = model_xfer(we, addr, wd, exp_err);
    REQ = 1'b1; CS = 1'b1; iWE = we; iAddress = addr; WriteData = wd;
    @(posedge CLK);
    for (int k = 0; k <= w + 1; k++) begin
      @(negedge CLK);
      check($sformatf("ack[%h k=%0d]", addr, k), 32'(ack), 32'(k == w));
      check($sformatf("busy[%h k=%0d]", addr, k), 32'(busy), 32'(k <= w));
      check($sformatf("rdata[%h k=%0d]", addr, k), rdata, (k == w) ? exp_rd : 32'd0);
      if (k == w) check($sformatf("err[%h]", addr), 32'(err), 32'(exp_err));
      if (glitch && k == 0) begin
        iAddress  = addr ^ 32'h3;
        iWE       = ~we;
        WriteData = $urandom;
      end else begin
        REQ       = 1'b0;
        iAddress  = $urandom;
        WriteData = $urandom;
        iWE       = 1'($urandom);
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    int unsigned r;
    sel = 1'b0; RST_n = 1'b0; REQ = 1'b0; CS = 1'b0; iWE = 1'b0;
    iAddress = '0; WriteData = '0;
    repeat (2) @(negedge CLK);
    check("rst_ack",   32'(ack),  32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_err",   32'(err),  32'd0);
    check("rst_rdata", rdata,     32'd0);

    // Released at a negedge so the very next rising edge must accept.
    RST_n = 1'b1;
    addr_set = '{0, 5, 7, 1023};
    repeat (8) addr_set.push_back($urandom_range(0, 1023));
    foreach (addr_set[i]) xfer(1'b1, addr_set[i], $urandom, 1'b0);

    xfer(1'b1, 32'd5, 32'hDEAD_BEEF, 1'b0);
    xfer(1'b0, 32'd5, 32'd0, 1'b0);

    xfer(1'b0, 32'd1024, 32'd0, 1'b0);
    xfer(1'b0, 32'd0, 32'd0, 1'b0);
    xfer(1'b1, 32'h8000_0005, $urandom, 1'b0);
    xfer(1'b1, 32'd1029, $urandom, 1'b0);
    xfer(1'b0, 32'd5, 32'd0, 1'b0);

    xfer(1'b0, 32'd7, 32'd0, 1'b1);

    // Abort a write during its wait phase.
    REQ = 1'b1; CS = 1'b1; iWE = 1'b1; iAddress = 32'd7; WriteData = 32'h1234_5678;
    @(posedge CLK);
    @(negedge CLK);
    check("busy_before_abort", 32'(busy), 32'd1);
    RST_n = 1'b0; REQ = 1'b0;
    #1;
    check("abort_ack",   32'(ack),  32'd0);
    check("abort_busy",  32'(busy), 32'd0);
    check("abort_err",   32'(err),  32'd0);
    check("abort_rdata", rdata,     32'd0);
    repeat (3) begin
      @(negedge CLK);
      check("abort_no_ack", 32'(ack), 32'd0);
    end
    RST_n = 1'b1;
    xfer(1'b0, 32'd7, 32'd0, 1'b0);

    // Chip select low: request must be invisible.
    REQ = 1'b1; CS = 1'b0; iWE = 1'b1; iAddress = 32'd5; WriteData = 32'hCAFE_F00D;
    repeat (3) begin
      @(negedge CLK);
      check("cs0_busy", 32'(busy), 32'd0);
      check("cs0_ack",  32'(ack),  32'd0);
    end
    REQ = 1'b0;
    xfer(1'b0, 32'd5, 32'd0, 1'b0);

    repeat (40) begin
      r = $urandom_range(0, 9);
      if (r == 0)      a = 32'd1024 + $urandom_range(0, 4096);
      else if (r == 1) a = $urandom | 32'h8000_0000;
      else             a = addr_set[$urandom_range(0, addr_set.size() - 1)];
      xfer(1'($urandom), a, $urandom, r == 2);
    end

    // Zero-wait instance: back-to-back accesses every two cycles.
    sel = 1'b1;
    xfer(1'b1, 32'd0, $urandom, 1'b0);
    xfer(1'b1, 32'd1023, $urandom, 1'b0);
    xfer(1'b0, 32'd0, 32'd0, 1'b0);
    xfer(1'b0, 32'd1023, 32'd0, 1'b0);
    xfer(1'b0, 32'd1024, 32'd0, 1'b0);
    xfer(1'b0, 32'd1023, 32'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit words; window 0x192E..0x1D2D maps to offsets 0..1023.
REQ-002 SHALL have parameter WAIT_STATES, default 2, wait cycles between acceptance and response; legal range 0..15.
REQ-003 SHALL have one clock and an asynchronous active-low reset, with the following ports:
- CLK  in  1  clock; all state on rising edge.
- RST_n  in  1  asynchronous active-low reset.
- CS  in  1  chip select from the address decoder.
- iWE  in  1  qualified write enable from the address decoder.
- iAddress  in  32  word offset from the window base.
- REQ  in  1  request strobe; a transfer is requested when REQ=1 and CS=1.
- WriteData  in  32  store data.
- ReadData  out  32  load data, valid while ACK=1.
- ACK  out  1  one-cycle completion pulse.
- ERR  out  1  out-of-range flag, valid only while ACK=1.
- BUSY  out  1  high from acceptance until the ACK cycle inclusive.

Function
REQ-004 SHALL implement FSM states IDLE, WAIT, RESP, encoded in the shared package.
REQ-005 In IDLE, REQ=1 and CS=1 at a clock edge SHALL accept the request:
- latch iAddress, iWE and WriteData;
- go to WAIT if WAIT_STATES>0, else go to RESP.
REQ-006 In WAIT, a 4-bit counter loaded with WAIT_STATES-1 at acceptance SHALL decrement each cycle; at 0 the FSM SHALL go to RESP.
REQ-007 In RESP, for exactly one cycle, ACK SHALL be 1 and the FSM SHALL return to IDLE; ACK latency from the accepting edge = WAIT_STATES+1 cycles.
REQ-008 REQ, CS, iWE, iAddress and WriteData changes while BUSY=1 SHALL be ignored; there is no queueing.
REQ-009 A request with CS=0 SHALL be ignored regardless of REQ.
REQ-010 Write with latched offset < DEPTH SHALL commit WriteData to the array on the RESP edge; ReadData SHALL be 0 during a write ACK.
REQ-011 Read with latched offset < DEPTH SHALL present the array word on ReadData during the RESP cycle.
REQ-012 Latched offset >= DEPTH SHALL assert ERR with ACK, force ReadData=0, and suppress any write; the full 32-bit compare is required, with no truncation or wrap.
REQ-013 ReadData SHALL be 0 whenever ACK=0.
REQ-014 A new request MAY be accepted in the IDLE cycle immediately after ACK; minimum request spacing is WAIT_STATES+2 cycles.
REQ-015 A read of a word written by the immediately previous transfer SHALL return the new data.

Reset
REQ-016 RST_n=0 SHALL immediately force state=IDLE, counter=0, ACK=0, ERR=0, BUSY=0, ReadData=0, and clear the latched request.
REQ-017 Reset mid-transfer SHALL abort the transfer with no ACK and no array write; array contents SHALL NOT be cleared by reset.
REQ-018 The first request SHALL be accepted on the first rising edge after RST_n deasserts.

Structure
REQ-019 The shared package SHALL hold the state enum, the default DEPTH (1024), and the window constants 0x192E/0x1D2D.
REQ-020 Storage SHALL be the sub-module data_mem_array: synchronous write, combinational read, DEPTH x 32, no reset.
REQ-021 The FSM, counter, request latch and range check SHALL reside in data_mem_responder.

Verification
REQ-022 Write 0xDEADBEEF at offset 5, then read offset 5 (WAIT_STATES=2) -> ACK at cycle 3 after each acceptance, ReadData=0xDEADBEEF, ERR=0.
REQ-023 Read offset 1024 -> ACK with ERR=1 and ReadData=0; a subsequent read of offset 0 shows no corruption.
REQ-024 Pulse REQ while BUSY=1 with a different address -> ignored, exactly one ACK, the original address is served.
REQ-025 Deassert RST_n during WAIT of a write of 0x12345678 to offset 7 -> no ACK; a later read of offset 7 returns the prior value.
REQ-026 WAIT_STATES=0, back-to-back reads of offsets 0 and 1023 -> ACK 1 cycle after each acceptance, accepted every 2 cycles.
REQ-027 REQ=1 with CS=0 -> BUSY stays 0, no ACK, array unchanged.
